phase_sequencer: RTL and testbench

Generates the 3-bit instruction phase and the halt flag consumed by control_unit, which turns them into the p1..p5 phase enables.
Phases advance fetch → decode → execute → memory → writeback. The memory phase can be skipped per instruction.
Supports free-run, single-step and halt-instruction termination. Counts retired instructions for debug.
Sits between the instruction decoder (halt/skip requests) and control_unit (phase/halt consumer).

---
 rtl/phase_sequencer_pkg.sv | 30 +++
 rtl/phase_sequencer_if.sv | 24 ++
 rtl/phase_sequencer_rise_detect.sv | 16 +
 rtl/phase_sequencer.sv | 94 +++++++++
 tb/tb_phase_sequencer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared phase/state encodings for phase_sequencer, control_unit and the decoder.
package phase_sequencer_pkg;

  localparam logic [2:0] PH_FETCH  = 3'd0;
  localparam logic [2:0] PH_DECODE = 3'd1;
  localparam logic [2:0] PH_EXEC   = 3'd2;
  localparam logic [2:0] PH_MEM    = 3'd3;
  localparam logic [2:0] PH_WB     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  // Phase following ph inside an instruction; the memory phase is bypassed when skip is set.
  function automatic logic [2:0] next_phase(input logic [2:0] ph, input logic skip);
    logic [2:0] nxt;
    case (ph)
      PH_FETCH:  nxt = PH_DECODE;
      PH_DECODE: nxt = PH_EXEC;
      PH_EXEC:   nxt = skip ? PH_WB : PH_MEM;
      PH_MEM:    nxt = PH_WB;
      default:   nxt = PH_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the decoder side (master) and the phase sequencer (slave).
interface phase_sequencer_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   run;
  logic                   step;
  logic                   halt_req;
  logic                   skip_mem;
  logic [2:0]             phase;
  logic                   halt;
  logic                   active;
  logic                   instr_start;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output run, step, halt_req, skip_mem,
    input  phase, halt, active, instr_start, instr_count
  );

  modport slave (
    input  run, step, halt_req, skip_mem,
    output phase, halt, active, instr_start, instr_count
  );
endinterface

// File: rtl/phase_sequencer_rise_detect.sv
// One-bit registered rising-edge detector; pulse is high while in_i is high for its first cycle.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= in_i;
  end

  assign rise_o = in_i & ~prev_q;
endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks fetch..writeback, handles run/step/halt, counts retired instructions.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  phase_sequencer_if.slave  bus
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t             state_q, state_d;
  logic [2:0]             phase_q, phase_d;
  logic                   instr_start_q, instr_start_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   halt_latch_q, halt_latch_d;
  logic                   step_rise;

  rise_detect u_step_rise (
    .clock  (clock),
    .reset  (reset),
    .in_i   (bus.step),
    .rise_o (step_rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_FETCH;
      instr_start_q <= 1'b0;
      count_q       <= '0;
      halt_latch_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      instr_start_q <= instr_start_d;
      count_q       <= count_d;
      halt_latch_q  <= halt_latch_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    instr_start_d = 1'b0;
    count_d       = count_q;
    halt_latch_d  = halt_latch_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = PH_FETCH;
        // run has priority; a coincident step edge is simply dropped
        if (bus.run) begin
          state_d       = ST_RUN;
          instr_start_d = 1'b1;
        end else if (step_rise) begin
          state_d       = ST_STEP;
          instr_start_d = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        if (phase_q == PH_WB) begin
          count_d = count_q + CNT_ONE;
          phase_d = PH_FETCH;
          if (halt_latch_q) begin
            state_d = ST_HALTED;
          end else if (state_q == ST_RUN && bus.run) begin
            instr_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = next_phase(phase_q, bus.skip_mem);
          if (phase_q == PH_DECODE && bus.halt_req) halt_latch_d = 1'b1;
        end
      end
      ST_HALTED: phase_d = PH_FETCH;
      default: begin
        state_d = ST_IDLE;
        phase_d = PH_FETCH;
      end
    endcase
  end

  always_comb begin
    bus.phase       = phase_q;
    bus.instr_start = instr_start_q;
    bus.instr_count = count_q;
    bus.active      = (state_q == ST_RUN) || (state_q == ST_STEP);
    bus.halt        = (state_q == ST_HALTED);
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer; one line per checked transaction.
module tb_phase_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   fails = 0;

  phase_sequencer_if #(.COUNT_WIDTH(16)) bus ();

  phase_sequencer #(.COUNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks all five outputs in one transaction and prints it.
  task automatic expect_out(input string tag, input int ph, input bit st, input bit act,
                            input bit hlt, input int cnt);
    $display("%0t %s phase=%0d start=%0b active=%0b halt=%0b count=%0d",
             $time, tag, bus.phase, bus.instr_start, bus.active, bus.halt, bus.instr_count);
    check({tag, ".phase"}, 32'(bus.phase), 32'(ph));
    check({tag, ".start"}, 32'(bus.instr_start), 32'(st));
    check({tag, ".active"}, 32'(bus.active), 32'(act));
    check({tag, ".halt"}, 32'(bus.halt), 32'(hlt));
    check({tag, ".count"}, 32'(bus.instr_count), 32'(cnt));
  endtask

  initial begin
    int fr_ph [11] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    int fr_ct [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2};

    bus.run = 1'b0; bus.step = 1'b0; bus.halt_req = 1'b0; bus.skip_mem = 1'b0;
    tick(); tick();
    reset = 1'b0;
    expect_out("reset", 0, 0, 0, 0, 0);

    // Free run: 11 cycles
    bus.run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      expect_out($sformatf("free%0d", i), fr_ph[i], fr_ph[i] == 0, 1, 0, fr_ct[i]);
    end

    // Stop at boundary: drop run while phase 2
    tick(); expect_out("stop_p1", 1, 0, 1, 0, 2);
    tick(); expect_out("stop_p2", 2, 0, 1, 0, 2);
    bus.run = 1'b0;
    tick(); expect_out("stop_p3", 3, 0, 1, 0, 2);
    tick(); expect_out("stop_p4", 4, 0, 1, 0, 2);
    tick(); expect_out("stop_idle", 0, 0, 0, 0, 3);
    tick(); expect_out("stop_hold", 0, 0, 0, 0, 3);

    // Skip memory: 0,1,2,4,0
    bus.run = 1'b1;
    tick(); expect_out("skip_p0", 0, 1, 1, 0, 3);
    tick(); expect_out("skip_p1", 1, 0, 1, 0, 3);
    tick(); expect_out("skip_p2", 2, 0, 1, 0, 3);
    bus.skip_mem = 1'b1; bus.run = 1'b0;
    tick(); expect_out("skip_p4", 4, 0, 1, 0, 3);
    bus.skip_mem = 1'b0;
    tick(); expect_out("skip_idle", 0, 0, 0, 0, 4);

    // Single step held 3 cycles, second edge during execution ignored
    bus.step = 1'b1;
    tick(); expect_out("step_p0", 0, 1, 1, 0, 4);
    tick(); expect_out("step_p1", 1, 0, 1, 0, 4);
    tick(); expect_out("step_p2", 2, 0, 1, 0, 4);
    bus.step = 1'b0;
    tick(); expect_out("step_p3", 3, 0, 1, 0, 4);
    bus.step = 1'b1;
    tick(); expect_out("step_p4", 4, 0, 1, 0, 4);
    bus.step = 1'b0;
    tick(); expect_out("step_idle", 0, 0, 0, 0, 5);
    tick(); expect_out("step_hold", 0, 0, 0, 0, 5);

    // Reset mid-instruction (phase 3)
    bus.run = 1'b1;
    tick(); tick(); tick(); tick();
    expect_out("rst_pre", 3, 0, 1, 0, 5);
    reset = 1'b1; bus.run = 1'b0;
    tick();
    reset = 1'b0;
    expect_out("rst_mid", 0, 0, 0, 0, 0);

    // run and step edge together: RUN wins, no trailing step instruction
    bus.run = 1'b1; bus.step = 1'b1;
    tick(); expect_out("both_p0", 0, 1, 1, 0, 0);
    bus.run = 1'b0;
    tick(); tick(); tick();
    tick(); expect_out("both_p4", 4, 0, 1, 0, 0);
    tick(); expect_out("both_idle", 0, 0, 0, 0, 1);
    tick(); expect_out("both_hold", 0, 0, 0, 0, 1);
    bus.step = 1'b0;

    // Halt on instruction 3; halt_req outside phase 1 is ignored on instruction 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.halt_req = (i != 1);
    end
    bus.halt_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    expect_out("halt_i2_p4", 4, 0, 1, 0, 1);
    tick(); expect_out("halt_i3_p0", 0, 1, 1, 0, 2);
    tick();
    bus.halt_req = 1'b1;
    expect_out("halt_i3_p1", 1, 0, 1, 0, 2);
    tick();
    bus.halt_req = 1'b0;
    tick();
    tick(); expect_out("halt_i3_p4", 4, 0, 1, 0, 2);
    tick(); expect_out("halted", 0, 0, 0, 1, 3);
    bus.run = 1'b0; bus.step = 1'b1;
    tick();
    bus.run = 1'b1; bus.step = 1'b0;
    tick();
    bus.step = 1'b1;
    tick(); expect_out("halted_sticky", 0, 0, 0, 1, 3);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
